// File: rtl/seq_player_if.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// seq_player_if : strobe inputs and LED/status outputs of seq_player  rev 1.0
//////////////////////////////////////////////////////////////////////////////
interface seq_player_if #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 8
) ();
   logic                         tick;
   logic                         rec_stb;
   logic [WIDTH-1:0]             pat_in;
   logic                         pause_stb;
   logic                         clr_stb;
   logic [WIDTH-1:0]             leds;
   logic [$clog2(DEPTH+1)-1:0]   count;
   logic                         full;
   logic [1:0]                   state;

   modport master (
      output tick, rec_stb, pat_in, pause_stb, clr_stb,
      input  leds, count, full, state
   );

   modport slave (
      input  tick, rec_stb, pat_in, pause_stb, clr_stb,
      output leds, count, full, state
   );
endinterface
`default_nettype wire

// File: rtl/seq_player.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// seq_player : ring-buffer pattern recorder with tick-driven LED replay  rev 1.0
//////////////////////////////////////////////////////////////////////////////
module seq_player #(
   parameter int WIDTH     = 2,
   parameter int DEPTH     = 8,
   parameter bit LOOP      = 1'b1,
   parameter bit OVERWRITE = 1'b1
) (
   input wire          clk,
   input wire          rst_n,
   seq_player_if.slave bus
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = $clog2(DEPTH+1);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_head;
   logic [c_AW-1:0]  r_wptr;
   logic [c_AW-1:0]  r_idx;
   logic [c_CW-1:0]  r_count;
   logic [WIDTH-1:0] r_leds;
   state_t           r_state;

   logic [c_AW-1:0]  w_head_nxt;
   logic [c_AW-1:0]  w_wptr_nxt;
   logic [c_AW-1:0]  w_idx_nxt;
   logic [c_CW-1:0]  w_count_nxt;
   logic [WIDTH-1:0] w_leds_nxt;
   state_t           w_state_nxt;
   logic             w_wr_en;
   logic             w_full;
   logic             w_last;
   logic [c_AW-1:0]  w_rd_addr;
   logic [WIDTH-1:0] w_rd_data;

   assign w_full    = (r_count == c_CW'(DEPTH));
   assign w_last    = (c_CW'(r_idx) == (r_count - c_CW'(1)));
   assign w_rd_addr = r_head + r_idx;
   // Read uses the pre-edge head and contents, so a same-cycle write or overwrite never leaks in.
   assign w_rd_data = r_mem[w_rd_addr];

   always_comb begin
      w_head_nxt  = r_head;
      w_wptr_nxt  = r_wptr;
      w_idx_nxt   = r_idx;
      w_count_nxt = r_count;
      w_leds_nxt  = r_leds;
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;

      if (bus.clr_stb) begin
         w_head_nxt  = '0;
         w_wptr_nxt  = '0;
         w_idx_nxt   = '0;
         w_count_nxt = '0;
         w_leds_nxt  = '0;
         w_state_nxt = ST_EMPTY;
      end else begin
         if (bus.rec_stb) begin
            if (!w_full) begin
               w_wr_en     = 1'b1;
               w_wptr_nxt  = r_wptr + c_AW'(1);
               w_count_nxt = r_count + c_CW'(1);
            end else if (OVERWRITE) begin
               w_wr_en    = 1'b1;
               w_wptr_nxt = r_wptr + c_AW'(1);
               w_head_nxt = r_head + c_AW'(1);
            end
         end

         case (r_state)
            ST_EMPTY: begin
               if (bus.rec_stb) begin
                  w_state_nxt = ST_PLAY;
                  w_idx_nxt   = '0;
               end
            end
            ST_PLAY: begin
               if (bus.pause_stb) begin
                  w_state_nxt = ST_PAUSE;
               end else if (bus.tick) begin
                  w_leds_nxt = w_rd_data;
                  if (w_last) begin
                     if (LOOP) w_idx_nxt   = '0;
                     else      w_state_nxt = ST_DONE;
                  end else begin
                     w_idx_nxt = r_idx + c_AW'(1);
                  end
               end
            end
            ST_PAUSE: begin
               if (bus.pause_stb) w_state_nxt = ST_PLAY;
            end
            ST_DONE: begin
               if (bus.pause_stb) begin
                  w_state_nxt = ST_PLAY;
                  w_idx_nxt   = '0;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_wptr  <= '0;
         r_idx   <= '0;
         r_count <= '0;
         r_leds  <= '0;
         r_state <= ST_EMPTY;
      end else begin
         r_head  <= w_head_nxt;
         r_wptr  <= w_wptr_nxt;
         r_idx   <= w_idx_nxt;
         r_count <= w_count_nxt;
         r_leds  <= w_leds_nxt;
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wptr] <= bus.pat_in;
   end

   assign bus.leds  = r_leds;
   assign bus.count = r_count;
   assign bus.full  = w_full;
   assign bus.state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seq_player.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// tb_seq_player : three seq_player variants driven by shared directed strobes  rev 1.0
//////////////////////////////////////////////////////////////////////////////
module tb_seq_player;

   logic       clk;
   logic       rst_n;
   logic       r_tick;
   logic       r_rec;
   logic       r_pause;
   logic       r_clr;
   logic [3:0] r_pat;
   int         errors;
   int         checks;

   seq_player_if #(.WIDTH(4), .DEPTH(8)) if_a ();
   seq_player_if #(.WIDTH(4), .DEPTH(8)) if_b ();
   seq_player_if #(.WIDTH(4), .DEPTH(8)) if_c ();

   assign if_a.tick = r_tick;  assign if_a.rec_stb = r_rec;  assign if_a.pat_in = r_pat;
   assign if_a.pause_stb = r_pause;  assign if_a.clr_stb = r_clr;
   assign if_b.tick = r_tick;  assign if_b.rec_stb = r_rec;  assign if_b.pat_in = r_pat;
   assign if_b.pause_stb = r_pause;  assign if_b.clr_stb = r_clr;
   assign if_c.tick = r_tick;  assign if_c.rec_stb = r_rec;  assign if_c.pat_in = r_pat;
   assign if_c.pause_stb = r_pause;  assign if_c.clr_stb = r_clr;

   // a: loop + overwrite, b: loop + drop when full, c: one-shot
   seq_player #(.WIDTH(4), .DEPTH(8), .LOOP(1'b1), .OVERWRITE(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   seq_player #(.WIDTH(4), .DEPTH(8), .LOOP(1'b1), .OVERWRITE(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
   seq_player #(.WIDTH(4), .DEPTH(8), .LOOP(1'b0), .OVERWRITE(1'b1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic strobe(input logic t, input logic r, input logic p, input logic c, input logic [3:0] v);
      @(negedge clk);
      r_tick = t; r_rec = r; r_pause = p; r_clr = c; r_pat = v;
      @(negedge clk);
      r_tick = 1'b0; r_rec = 1'b0; r_pause = 1'b0; r_clr = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      checks++; if (if_a.leds !== 4'd0)  begin errors++; $display("FAIL reset_leds: got %0d expected 0", if_a.leds); end
      checks++; if (if_a.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", if_a.count); end
      checks++; if (if_a.full !== 1'b0)  begin errors++; $display("FAIL reset_full: got %0d expected 0", if_a.full); end
      checks++; if (if_a.state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", if_a.state); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_loop;
      logic [3:0] exp;
      strobe(0, 0, 0, 1, 4'd0);
      strobe(0, 1, 0, 0, 4'd1);
      strobe(0, 1, 0, 0, 4'd2);
      strobe(0, 1, 0, 0, 4'd3);
      checks++; if (if_a.count !== 4'd3) begin errors++; $display("FAIL loop_count: got %0d expected 3", if_a.count); end
      checks++; if (if_a.state !== 2'd1) begin errors++; $display("FAIL loop_state: got %0d expected 1", if_a.state); end
      checks++; if (if_a.leds !== 4'd0)  begin errors++; $display("FAIL loop_leds_pre: got %0d expected 0", if_a.leds); end
      for (int i = 0; i < 7; i++) begin
         strobe(1, 0, 0, 0, 4'd0);
         exp = 4'((i % 3) + 1);
         checks++;
         if (if_a.leds !== exp) begin
            errors++; $display("FAIL loop_leds[%0d]: got %0d expected %0d", i, if_a.leds, exp);
         end
      end
   endtask

   task automatic test_overwrite;
      logic [3:0] exp;
      strobe(0, 0, 0, 1, 4'd0);
      for (int i = 1; i <= 9; i++) strobe(0, 1, 0, 0, 4'(i));
      checks++; if (if_a.count !== 4'd8) begin errors++; $display("FAIL ovw_count: got %0d expected 8", if_a.count); end
      checks++; if (if_a.full !== 1'b1)  begin errors++; $display("FAIL ovw_full: got %0d expected 1", if_a.full); end
      for (int i = 0; i < 8; i++) begin
         strobe(1, 0, 0, 0, 4'd0);
         exp = 4'(i + 2);
         checks++;
         if (if_a.leds !== exp) begin
            errors++; $display("FAIL ovw_leds[%0d]: got %0d expected %0d", i, if_a.leds, exp);
         end
      end
      checks++; if (if_a.count !== 4'd8) begin errors++; $display("FAIL ovw_count_end: got %0d expected 8", if_a.count); end
   endtask

   task automatic test_no_overwrite;
      logic [3:0] exp;
      strobe(0, 0, 0, 1, 4'd0);
      for (int i = 1; i <= 7; i++) strobe(0, 1, 0, 0, 4'(i));
      checks++; if (if_b.full !== 1'b0) begin errors++; $display("FAIL novw_full7: got %0d expected 0", if_b.full); end
      strobe(0, 1, 0, 0, 4'd8);
      checks++; if (if_b.full !== 1'b1) begin errors++; $display("FAIL novw_full8: got %0d expected 1", if_b.full); end
      strobe(0, 1, 0, 0, 4'd9);
      checks++; if (if_b.count !== 4'd8) begin errors++; $display("FAIL novw_count: got %0d expected 8", if_b.count); end
      for (int i = 0; i < 8; i++) begin
         strobe(1, 0, 0, 0, 4'd0);
         exp = 4'(i + 1);
         checks++;
         if (if_b.leds !== exp) begin
            errors++; $display("FAIL novw_leds[%0d]: got %0d expected %0d", i, if_b.leds, exp);
         end
      end
   endtask

   task automatic test_oneshot;
      strobe(0, 0, 0, 1, 4'd0);
      strobe(0, 1, 0, 0, 4'd5);
      strobe(0, 1, 0, 0, 4'd10);
      strobe(1, 0, 0, 0, 4'd0);
      checks++; if (if_c.leds !== 4'd5)   begin errors++; $display("FAIL one_t1: got %0d expected 5", if_c.leds); end
      strobe(1, 0, 0, 0, 4'd0);
      checks++; if (if_c.leds !== 4'd10)  begin errors++; $display("FAIL one_t2: got %0d expected 10", if_c.leds); end
      strobe(1, 0, 0, 0, 4'd0);
      checks++; if (if_c.leds !== 4'd10)  begin errors++; $display("FAIL one_t3: got %0d expected 10", if_c.leds); end
      checks++; if (if_c.state !== 2'd3)  begin errors++; $display("FAIL one_done: got %0d expected 3", if_c.state); end
      strobe(0, 0, 1, 0, 4'd0);
      checks++; if (if_c.state !== 2'd1)  begin errors++; $display("FAIL one_restart: got %0d expected 1", if_c.state); end
      strobe(1, 0, 0, 0, 4'd0);
      checks++; if (if_c.leds !== 4'd5)   begin errors++; $display("FAIL one_replay: got %0d expected 5", if_c.leds); end
   endtask

   task automatic test_pause;
      strobe(0, 0, 0, 1, 4'd0);
      strobe(0, 1, 0, 0, 4'd5);
      strobe(0, 1, 0, 0, 4'd10);
      strobe(1, 0, 0, 0, 4'd0);
      checks++; if (if_a.leds !== 4'd5)  begin errors++; $display("FAIL pause_first: got %0d expected 5", if_a.leds); end
      strobe(0, 0, 1, 0, 4'd0);
      checks++; if (if_a.state !== 2'd2) begin errors++; $display("FAIL pause_state: got %0d expected 2", if_a.state); end
      for (int i = 0; i < 5; i++) strobe(1, 0, 0, 0, 4'd0);
      checks++; if (if_a.leds !== 4'd5)  begin errors++; $display("FAIL pause_hold: got %0d expected 5", if_a.leds); end
      strobe(0, 0, 1, 0, 4'd0);
      strobe(1, 0, 0, 0, 4'd0);
      checks++; if (if_a.leds !== 4'd10) begin errors++; $display("FAIL pause_resume: got %0d expected 10", if_a.leds); end
      strobe(1, 0, 1, 0, 4'd0);
      checks++; if (if_a.state !== 2'd2) begin errors++; $display("FAIL pause_tick_state: got %0d expected 2", if_a.state); end
      checks++; if (if_a.leds !== 4'd10) begin errors++; $display("FAIL pause_tick_leds: got %0d expected 10", if_a.leds); end
   endtask

   task automatic test_same_cycle;
      strobe(0, 0, 0, 1, 4'd0);
      strobe(1, 1, 0, 0, 4'd7);
      checks++; if (if_a.count !== 4'd1) begin errors++; $display("FAIL empty_tickrec_count: got %0d expected 1", if_a.count); end
      checks++; if (if_a.leds !== 4'd0)  begin errors++; $display("FAIL empty_tickrec_leds: got %0d expected 0", if_a.leds); end
      strobe(1, 0, 0, 0, 4'd0);
      checks++; if (if_a.leds !== 4'd7)  begin errors++; $display("FAIL empty_tickrec_next: got %0d expected 7", if_a.leds); end
      strobe(0, 1, 0, 1, 4'd3);
      checks++; if (if_a.count !== 4'd0) begin errors++; $display("FAIL clrrec_count: got %0d expected 0", if_a.count); end
      checks++; if (if_a.leds !== 4'd0)  begin errors++; $display("FAIL clrrec_leds: got %0d expected 0", if_a.leds); end
      checks++; if (if_a.state !== 2'd0) begin errors++; $display("FAIL clrrec_state: got %0d expected 0", if_a.state); end
   endtask

   task automatic test_async_reset;
      strobe(0, 1, 0, 0, 4'd1);
      strobe(0, 1, 0, 0, 4'd2);
      strobe(1, 0, 0, 0, 4'd0);
      checks++; if (if_a.leds !== 4'd1) begin errors++; $display("FAIL arst_pre: got %0d expected 1", if_a.leds); end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (if_a.leds !== 4'd0)  begin errors++; $display("FAIL arst_leds: got %0d expected 0", if_a.leds); end
      checks++; if (if_a.count !== 4'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", if_a.count); end
      checks++; if (if_a.state !== 2'd0) begin errors++; $display("FAIL arst_state: got %0d expected 0", if_a.state); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      errors = 0; checks = 0;
      rst_n = 1'b0;
      r_tick = 1'b0; r_rec = 1'b0; r_pause = 1'b0; r_clr = 1'b0; r_pat = 4'd0;
      test_reset();
      test_loop();
      test_overwrite();
      test_no_overwrite();
      test_oneshot();
      test_pause();
      test_same_cycle();
      test_async_reset();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
